// File: rtl/cube_line_engine.sv
// Cube line engine: rotates the 8 cube vertices once per frame and produces
// 12 screen-space edges. Edges are built in a shadow buffer and copied to the
// output only on a frame_start edge, so downstream never sees a partial frame.

package types;
  localparam int LINE_BITS = 8;
  typedef struct packed {
    logic [LINE_BITS-1:0] x0;
    logic [LINE_BITS-1:0] y0;
    logic [LINE_BITS-1:0] x1;
    logic [LINE_BITS-1:0] y1;
  } line_t;
endpackage

module cube_line_engine #(
  parameter int CUBE_R     = 48,
  parameter int CENTER_X   = 80,
  parameter int CENTER_Y   = 60,
  parameter int ANGLE_STEP = 1,
  parameter int TILT_COS   = 110,
  parameter int TILT_SIN   = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                frame_start_i,
  input  logic                                enable_i,
  output logic [12*4*types::LINE_BITS-1:0]    lines_o,
  output logic                                lines_valid_o,
  output logic                                busy_o,
  output logic [7:0]                          angle_o
);
  localparam int LB = types::LINE_BITS;
  localparam logic signed [19:0] R20  = 20'(CUBE_R);
  localparam logic signed [19:0] CX   = 20'(CENTER_X);
  localparam logic signed [19:0] CY   = 20'(CENTER_Y);
  localparam logic signed [19:0] TC   = 20'(TILT_COS);
  localparam logic signed [19:0] TS   = 20'(TILT_SIN);
  localparam logic signed [19:0] MAXS = 20'((1 << LB) - 1);

  // First quarter of round(127*sin(2*pi*i/256)).
  localparam logic [6:0] SIN_LUT [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127};

  // Edge endpoints; lower vertex index is always the first endpoint.
  localparam logic [2:0] EDGE_A [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1,
                                         3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [2:0] EDGE_B [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3,
                                         3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};

  typedef enum logic [2:0] {S_IDLE, S_ROT_A, S_ROT_B, S_EDGE, S_DONE} state_t;

  // Full-wave sine from the quarter table by quadrant folding.
  function automatic logic signed [7:0] sin8(input logic [7:0] a);
    logic [6:0] m;
    if (a[6]) m = (a[5:0] == 6'd0) ? 7'd127 : SIN_LUT[6'd0 - a[5:0]];
    else      m = SIN_LUT[a[5:0]];
    sin8 = a[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  // Saturate a signed screen coordinate into [0, 2^LB-1].
  function automatic logic [LB-1:0] clamp(input logic signed [19:0] v);
    if (v < 0)         clamp = '0;
    else if (v > MAXS) clamp = '1;
    else               clamp = v[LB-1:0];
  endfunction

  state_t              r_state, w_state_nx;
  logic [2:0]          r_k;
  logic [3:0]          r_e;
  logic [7:0]          r_angle, r_cangle;
  logic                r_shadow_valid, r_lines_valid;
  types::line_t [11:0] r_shadow, r_lines;
  logic signed [19:0]  r_xr, r_zr;
  logic [LB-1:0]       r_vx [8];
  logic [LB-1:0]       r_vy [8];

  logic signed [19:0]  w_c, w_s, w_x, w_y, w_z, w_xr, w_zr, w_sy;

  assign w_c  = sin8(r_cangle + 8'd64);
  assign w_s  = sin8(r_cangle);
  assign w_x  = r_k[2] ? R20 : -R20;
  assign w_y  = r_k[1] ? R20 : -R20;
  assign w_z  = r_k[0] ? R20 : -R20;
  assign w_xr = (w_x * w_c - w_z * w_s) >>> 7;
  assign w_zr = (w_x * w_s + w_z * w_c) >>> 7;
  assign w_sy = (w_y * TC - r_zr * TS) >>> 7;

  assign lines_o       = r_lines;
  assign lines_valid_o = r_lines_valid;
  assign busy_o        = (r_state != S_IDLE);
  assign angle_o       = r_angle;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Next state; frame_start restarts from any state, aborting work in flight.
  always_comb begin
    w_state_nx = r_state;
    if (frame_start_i) w_state_nx = S_ROT_A;
    else begin
      case (r_state)
        S_IDLE:  w_state_nx = S_IDLE;
        S_ROT_A: w_state_nx = S_ROT_B;
        S_ROT_B: w_state_nx = (r_k == 3'd7) ? S_EDGE : S_ROT_A;
        S_EDGE:  w_state_nx = (r_e == 4'd11) ? S_DONE : S_EDGE;
        S_DONE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath: angle bookkeeping, commit, vertex transform and edge build.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k            <= '0;
      r_e            <= '0;
      r_angle        <= '0;
      r_cangle       <= '0;
      r_shadow_valid <= 1'b0;
      r_lines_valid  <= 1'b0;
      r_shadow       <= '0;
      r_lines        <= '0;
      r_xr           <= '0;
      r_zr           <= '0;
      for (int i = 0; i < 8; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
      end
    end else if (frame_start_i) begin
      // Only a fully built shadow is published; an aborted one is dropped.
      if (r_shadow_valid) begin
        r_lines       <= r_shadow;
        r_lines_valid <= 1'b1;
      end
      r_shadow_valid <= 1'b0;
      r_cangle       <= r_angle;
      if (enable_i) r_angle <= r_angle + 8'(ANGLE_STEP);
      r_k <= '0;
      r_e <= '0;
    end else begin
      case (r_state)
        S_ROT_A: begin
          r_xr <= w_xr;
          r_zr <= w_zr;
        end
        S_ROT_B: begin
          r_vx[r_k] <= clamp(CX + r_xr);
          r_vy[r_k] <= clamp(CY + w_sy);
          r_k       <= r_k + 3'd1;
        end
        S_EDGE: begin
          r_shadow[r_e] <= {r_vx[EDGE_A[r_e]], r_vy[EDGE_A[r_e]],
                            r_vx[EDGE_B[r_e]], r_vy[EDGE_B[r_e]]};
          r_e <= r_e + 4'd1;
        end
        S_DONE: r_shadow_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
